// File: rtl/ibex_rf_erase_scheduler_if.sv
// Bundle of the writeback-side and security-side signals of the erase
// scheduler. The master modport belongs to the core/security unit side and
// the slave modport to the scheduler itself.
interface ibex_rf_erase_scheduler_if #(
    parameter int DataWidth = 32
);
    // core writeback
    logic                 core_we_i;
    logic [4:0]           core_waddr_i;
    logic [DataWidth-1:0] core_wdata_i;
    logic                 core_stall_o;
    // security unit erase request
    logic                 ers_req_i;
    logic [31:0]          ers_mask_i;
    logic                 ers_ready_o;
    logic                 ers_busy_o;
    logic                 ers_done_o;
    // register file write port
    logic                 we_a_o;
    logic [4:0]           waddr_a_o;
    logic [DataWidth-1:0] wdata_a_o;

    modport master (
        output core_we_i, core_waddr_i, core_wdata_i, ers_req_i, ers_mask_i,
        input  core_stall_o, ers_ready_o, ers_busy_o, ers_done_o,
               we_a_o, waddr_a_o, wdata_a_o
    );

    modport slave (
        input  core_we_i, core_waddr_i, core_wdata_i, ers_req_i, ers_mask_i,
        output core_stall_o, ers_ready_o, ers_busy_o, ers_done_o,
               we_a_o, waddr_a_o, wdata_a_o
    );
endinterface

// File: rtl/ibex_rf_erase_scheduler.sv
// Register file erase scheduler: steals idle writeback slots to zero-write
// the architectural registers named by an erase mask, one per cycle, lowest
// index first. If the core keeps the write port busy for StallThreshold
// consecutive cycles, the core write is stalled so the erase can progress.
module ibex_rf_erase_scheduler #(
    parameter bit RV32E          = 1'b0,
    parameter int DataWidth      = 32,
    parameter int StallThreshold = 8
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    ibex_rf_erase_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [7:0]  StallCnt  = 8'(StallThreshold);
    // x0 is never erasable; RV32E additionally drops x16..x31
    localparam logic [31:0] ValidMask = RV32E ? 32'h0000_FFFE : 32'hFFFF_FFFE;

    state_e      state_q;
    logic [31:0] pending_q, pending_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ready_q, busy_q, done_q;

    logic        in_erase;
    logic        core_wr_nz;
    logic        stall_cond;
    logic        erase_slot;
    logic [4:0]  sel_idx;
    logic [31:0] req_mask;
    logic        accept;

    assign in_erase   = (state_q == ERASE);
    assign core_wr_nz = bus.core_we_i && (bus.core_waddr_i != 5'd0);
    assign stall_cond = in_erase && (cnt_q == StallCnt) && core_wr_nz;
    // erase takes the slot when the core is idle, writes x0, or is starved out
    assign erase_slot = in_erase && (!core_wr_nz || stall_cond);
    assign req_mask   = bus.ers_mask_i & ValidMask;
    assign accept     = (state_q == IDLE) && bus.ers_req_i;

    // Priority encoder: lowest pending register index wins
    always_comb begin
        sel_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = 5'(i);
        end
    end

    // Pending/counter update for the current ERASE cycle
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (in_erase) begin
            if (erase_slot) begin
                pending_d[sel_idx] = 1'b0;
                cnt_d              = 8'd0;
            end else begin
                // core owns the slot: its fresh value must survive the erase
                pending_d[bus.core_waddr_i] = 1'b0;
                if (cnt_q != StallCnt) cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Write port mux: erase slot forces a zero write, otherwise core passes
    always_comb begin
        bus.we_a_o    = bus.core_we_i;
        bus.waddr_a_o = bus.core_waddr_i;
        bus.wdata_a_o = bus.core_wdata_i;
        if (erase_slot) begin
            bus.we_a_o    = 1'b1;
            bus.waddr_a_o = sel_idx;
            bus.wdata_a_o = {DataWidth{1'b0}};
        end
    end

    assign bus.core_stall_o = stall_cond;
    assign bus.ers_ready_o  = ready_q;
    assign bus.ers_busy_o   = busy_q;
    assign bus.ers_done_o   = done_q;

    // Sequencer FSM with registered handshake/status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pending_q <= req_mask;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        if (req_mask == 32'd0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERASE;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ERASE: begin
                    pending_q <= pending_d;
                    cnt_q     <= cnt_d;
                    if (pending_d == 32'd0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= '0;
                    cnt_q     <= '0;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rf_erase_scheduler.sv
// Directed bench for the erase scheduler. A small register file array
// downstream of the write port lets the bench check what actually landed.
module tb_ibex_rf_erase_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ibex_rf_erase_scheduler_if #(.DataWidth(32)) bus  ();
    ibex_rf_erase_scheduler_if #(.DataWidth(32)) bus2 ();

    ibex_rf_erase_scheduler #(.RV32E(1'b0), .DataWidth(32), .StallThreshold(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    ibex_rf_erase_scheduler #(.RV32E(1'b1), .DataWidth(32), .StallThreshold(8)) dut_e (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus2)
    );

    logic [31:0] rf [32];

    always @(posedge clk) begin
        if (bus.we_a_o) rf[bus.waddr_a_o] <= bus.wdata_a_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic core_idle();
        bus.core_we_i    = 1'b0;
        bus.core_waddr_i = 5'd0;
        bus.core_wdata_i = 32'd0;
        bus.ers_req_i    = 1'b0;
        bus.ers_mask_i   = 32'd0;
    endtask

    initial begin
        core_idle();
        bus2.core_we_i    = 1'b0;
        bus2.core_waddr_i = 5'd0;
        bus2.core_wdata_i = 32'd0;
        bus2.ers_req_i    = 1'b0;
        bus2.ers_mask_i   = 32'd0;

        // ---------------- reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.ers_ready_o), 32'd1);
        chk("rst_busy",  32'(bus.ers_busy_o),  32'd0);
        chk("rst_done",  32'(bus.ers_done_o),  32'd0);
        chk("rst_stall", 32'(bus.core_stall_o), 32'd0);
        chk("rst_we",    32'(bus.we_a_o),      32'd0);
        chk("rst_waddr", 32'(bus.waddr_a_o),   32'd0);
        chk("rst_wdata", bus.wdata_a_o,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- preload x1..x6 through the pass-through path
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.core_we_i    = 1'b1;
            bus.core_waddr_i = 5'(i);
            bus.core_wdata_i = 32'hA0 + 32'(i);
            #1;
            chk("pre_we",    32'(bus.we_a_o),    32'd1);
            chk("pre_waddr", 32'(bus.waddr_a_o), 32'(i));
        end
        @(negedge clk);
        core_idle();

        // ---------------- A: idle core, mask 0x16 -> x1, x2, x4
        bus.ers_req_i  = 1'b1;
        bus.ers_mask_i = 32'h0000_0016;
        #1;
        chk("A_accept_ready", 32'(bus.ers_ready_o), 32'd1);
        @(negedge clk);
        core_idle();
        #1;
        chk("A_c1_busy",  32'(bus.ers_busy_o),  32'd1);
        chk("A_c1_ready", 32'(bus.ers_ready_o), 32'd0);
        chk("A_c1_we",    32'(bus.we_a_o),      32'd1);
        chk("A_c1_waddr", 32'(bus.waddr_a_o),   32'd1);
        chk("A_c1_wdata", bus.wdata_a_o,        32'd0);
        @(negedge clk); #1;
        chk("A_c2_waddr", 32'(bus.waddr_a_o),   32'd2);
        chk("A_c2_we",    32'(bus.we_a_o),      32'd1);
        @(negedge clk); #1;
        chk("A_c3_waddr", 32'(bus.waddr_a_o),   32'd4);
        chk("A_c3_done",  32'(bus.ers_done_o),  32'd0);
        @(negedge clk); #1;
        chk("A_c4_done",  32'(bus.ers_done_o),  32'd1);
        chk("A_c4_busy",  32'(bus.ers_busy_o),  32'd0);
        chk("A_c4_we",    32'(bus.we_a_o),      32'd0);
        @(negedge clk); #1;
        chk("A_c5_ready", 32'(bus.ers_ready_o), 32'd1);
        chk("A_c5_done",  32'(bus.ers_done_o),  32'd0);
        chk("A_rf_x1", rf[1], 32'd0);
        chk("A_rf_x2", rf[2], 32'd0);
        chk("A_rf_x3", rf[3], 32'hA3);
        chk("A_rf_x4", rf[4], 32'd0);

        // ---------------- B: mask x0 only -> immediate done, never busy
        @(negedge clk);
        bus.ers_req_i  = 1'b1;
        bus.ers_mask_i = 32'h0000_0001;
        #1;
        chk("B_accept_ready", 32'(bus.ers_ready_o), 32'd1);
        @(negedge clk);
        core_idle();
        #1;
        chk("B_done",  32'(bus.ers_done_o), 32'd1);
        chk("B_busy",  32'(bus.ers_busy_o), 32'd0);
        chk("B_we",    32'(bus.we_a_o),     32'd0);
        @(negedge clk); #1;
        chk("B_ready", 32'(bus.ers_ready_o), 32'd1);
        chk("B_done2", 32'(bus.ers_done_o),  32'd0);

        // ---------------- C: core writes x5 every cycle, mask 0x8 -> stall
        @(negedge clk);
        bus.ers_req_i    = 1'b1;
        bus.ers_mask_i   = 32'h0000_0008;
        bus.core_we_i    = 1'b1;
        bus.core_waddr_i = 5'd5;
        bus.core_wdata_i = 32'h55;
        @(negedge clk);
        bus.ers_req_i  = 1'b0;
        bus.ers_mask_i = 32'd0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("C_pass_stall", 32'(bus.core_stall_o), 32'd0);
            chk("C_pass_waddr", 32'(bus.waddr_a_o),    32'd5);
            @(negedge clk);
        end
        #1;
        chk("C_stall",       32'(bus.core_stall_o), 32'd1);
        chk("C_stall_we",    32'(bus.we_a_o),       32'd1);
        chk("C_stall_waddr", 32'(bus.waddr_a_o),    32'd3);
        chk("C_stall_wdata", bus.wdata_a_o,         32'd0);
        @(negedge clk); #1;
        chk("C_land_done",  32'(bus.ers_done_o),   32'd1);
        chk("C_land_stall", 32'(bus.core_stall_o), 32'd0);
        chk("C_land_waddr", 32'(bus.waddr_a_o),    32'd5);
        chk("C_land_wdata", bus.wdata_a_o,         32'h55);
        @(negedge clk);
        core_idle();
        #1;
        chk("C_rf_x3", rf[3], 32'd0);
        chk("C_rf_x5", rf[5], 32'h55);

        // ---------------- D: collision, core writes x5 in first ERASE cycle
        @(negedge clk);
        bus.ers_req_i  = 1'b1;
        bus.ers_mask_i = 32'h0000_0060;
        @(negedge clk);
        bus.ers_req_i    = 1'b0;
        bus.ers_mask_i   = 32'd0;
        bus.core_we_i    = 1'b1;
        bus.core_waddr_i = 5'd5;
        bus.core_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("D_c1_waddr", 32'(bus.waddr_a_o), 32'd5);
        chk("D_c1_wdata", bus.wdata_a_o,      32'hDEAD_BEEF);
        chk("D_c1_stall", 32'(bus.core_stall_o), 32'd0);
        @(negedge clk);
        core_idle();
        #1;
        chk("D_c2_we",    32'(bus.we_a_o),    32'd1);
        chk("D_c2_waddr", 32'(bus.waddr_a_o), 32'd6);
        @(negedge clk); #1;
        chk("D_c3_done",  32'(bus.ers_done_o), 32'd1);
        chk("D_c3_we",    32'(bus.we_a_o),     32'd0);
        chk("D_rf_x5", rf[5], 32'hDEAD_BEEF);
        chk("D_rf_x6", rf[6], 32'd0);
        @(negedge clk);

        // ---------------- E: RV32E, full mask -> x1..x15 only
        @(negedge clk);
        bus2.ers_req_i  = 1'b1;
        bus2.ers_mask_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bus2.ers_req_i  = 1'b0;
        bus2.ers_mask_i = 32'd0;
        for (int i = 1; i <= 15; i++) begin
            #1;
            chk("E_we",    32'(bus2.we_a_o),    32'd1);
            chk("E_waddr", 32'(bus2.waddr_a_o), 32'(i));
            chk("E_done_early", 32'(bus2.ers_done_o), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("E_done", 32'(bus2.ers_done_o), 32'd1);
        chk("E_we_after", 32'(bus2.we_a_o), 32'd0);

        // ---------------- F: reset mid-sequence
        @(negedge clk);
        bus.ers_req_i  = 1'b1;
        bus.ers_mask_i = 32'h0000_001E;
        @(negedge clk);
        core_idle();
        #1;
        chk("F_c1_waddr", 32'(bus.waddr_a_o), 32'd1);
        @(negedge clk); #1;
        chk("F_c2_waddr", 32'(bus.waddr_a_o), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("F_rst_ready", 32'(bus.ers_ready_o), 32'd1);
        chk("F_rst_busy",  32'(bus.ers_busy_o),  32'd0);
        chk("F_rst_done",  32'(bus.ers_done_o),  32'd0);
        chk("F_rst_we",    32'(bus.we_a_o),      32'd0);
        chk("F_rst_waddr", 32'(bus.waddr_a_o),   32'd0);
        @(negedge clk); #1;
        chk("F_rst_done2", 32'(bus.ers_done_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.ers_req_i  = 1'b1;
        bus.ers_mask_i = 32'h0000_0004;
        #1;
        chk("F_new_ready", 32'(bus.ers_ready_o), 32'd1);
        @(negedge clk);
        core_idle();
        #1;
        chk("F_new_busy",  32'(bus.ers_busy_o), 32'd1);
        chk("F_new_waddr", 32'(bus.waddr_a_o),  32'd2);
        @(negedge clk); #1;
        chk("F_new_done",  32'(bus.ers_done_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
